// File: rtl/aq_axis_pkt_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : aq_axis_pkt_fifo_if
// Brief    : AXI4-Stream beat channel (TVALID/TREADY/TDATA/TLAST).
// Revision : 1.0
// ============================================================================
interface aq_axis_pkt_fifo_if #(
    parameter int FIFO_WIDTH = 32
);
    logic                  TVALID;
    logic                  TREADY;
    logic [FIFO_WIDTH-1:0] TDATA;
    logic                  TLAST;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface
`default_nettype wire

// File: rtl/aq_axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aq_axis_pkt_fifo
// Brief    : Single-clock AXI4-Stream FIFO, optional store-and-forward
//            packet mode with oversize escape, thresholds and occupancy.
// Revision : 1.0
// ============================================================================
module aq_axis_pkt_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_WIDTH  = 32,
    parameter int PACKET_MODE = 1
) (
    input  wire logic                  ACLK,
    input  wire logic                  RST_N,
    input  wire logic                  FIFO_CLEAR,
    aq_axis_pkt_fifo_if.slave          S_AXIS,
    aq_axis_pkt_fifo_if.master         M_AXIS,
    input  wire logic [FIFO_DEPTH:0]   FIFO_WR_ALM_COUNT,
    input  wire logic [FIFO_DEPTH:0]   FIFO_RD_ALM_COUNT,
    output logic                       FIFO_WR_FULL,
    output logic                       FIFO_WR_ALM_FULL,
    output logic                       FIFO_RD_EMPTY,
    output logic                       FIFO_RD_ALM_EMPTY,
    output logic [FIFO_DEPTH:0]        FIFO_COUNT,
    output logic [FIFO_DEPTH:0]        FIFO_PKT_COUNT
);

    localparam int                    C_N_INT   = 1 << FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0]   C_N       = C_N_INT[FIFO_DEPTH:0];
    localparam logic [FIFO_DEPTH:0]   C_CNT_ONE = {{FIFO_DEPTH{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH-1:0] C_PTR_ONE = {{(FIFO_DEPTH-1){1'b0}}, 1'b1};

    logic [FIFO_WIDTH:0]   mem_q [C_N_INT];
    logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH:0]   count_q, count_d;
    logic [FIFO_DEPTH:0]   pkt_count_q, pkt_count_d;
    logic                  ready_en_q;

    logic                  s_ready;
    logic                  m_valid;
    logic                  wr_en;
    logic                  rd_en;
    logic                  rd_last;

    assign s_ready = ready_en_q && (count_q != C_N);
    assign wr_en   = S_AXIS.TVALID && s_ready;
    assign rd_en   = m_valid && M_AXIS.TREADY;
    assign rd_last = mem_q[rd_ptr_q][FIFO_WIDTH];

    generate
        if (PACKET_MODE != 0) begin : g_pkt_mode
            logic escape_q, escape_d;

            // Escape lets a packet larger than the FIFO stream cut-through
            // instead of deadlocking with a full FIFO and no complete packet.
            always_comb begin
                escape_d = escape_q;
                if (FIFO_CLEAR || (rd_en && rd_last)) begin
                    escape_d = 1'b0;
                end else if ((count_q == C_N) && (pkt_count_q == '0)) begin
                    escape_d = 1'b1;
                end
            end

            always_ff @(posedge ACLK or negedge RST_N) begin
                if (!RST_N) begin
                    escape_q <= 1'b0;
                end else begin
                    escape_q <= escape_d;
                end
            end

            assign m_valid = (pkt_count_q != '0) || (escape_q && (count_q != '0));
        end else begin : g_word_mode
            assign m_valid = (count_q != '0);
        end
    endgenerate

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pkt_count_d = pkt_count_q;
        if (FIFO_CLEAR) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pkt_count_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
            case ({wr_en && S_AXIS.TLAST, rd_en && rd_last})
                2'b10:   pkt_count_d = pkt_count_q + C_CNT_ONE;
                2'b01:   pkt_count_d = pkt_count_q - C_CNT_ONE;
                default: pkt_count_d = pkt_count_q;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            ready_en_q  <= 1'b1;
        end
    end

    // Storage is never reset; a write during FIFO_CLEAR lands in a slot the
    // cleared pointers treat as free, so it is harmless.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {S_AXIS.TLAST, S_AXIS.TDATA};
        end
    end

    assign S_AXIS.TREADY = s_ready;
    assign M_AXIS.TVALID = m_valid;
    assign M_AXIS.TDATA  = mem_q[rd_ptr_q][FIFO_WIDTH-1:0];
    assign M_AXIS.TLAST  = rd_last;

    assign FIFO_WR_FULL      = (count_q == C_N);
    assign FIFO_RD_EMPTY     = (count_q == '0);
    assign FIFO_WR_ALM_FULL  = (FIFO_WR_ALM_COUNT > C_N) ? 1'b1
                             : (count_q >= (C_N - FIFO_WR_ALM_COUNT));
    assign FIFO_RD_ALM_EMPTY = (count_q <= FIFO_RD_ALM_COUNT);
    assign FIFO_COUNT        = count_q;
    assign FIFO_PKT_COUNT    = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_aq_axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_aq_axis_pkt_fifo
// Brief    : Word-mode and packet-mode FIFOs driven side by side, checked
//            every cycle against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_aq_axis_pkt_fifo;

    localparam int D = 3;
    localparam int W = 16;
    localparam int N = 1 << D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         svalid = 1'b0;
    logic [W-1:0] sdata = '0;
    logic         slast = 1'b0;
    logic         mready = 1'b0;
    logic [D:0]   almw = 4'd2;
    logic [D:0]   almr = 4'd2;

    logic         full0, afull0, empty0, aempty0, full1, afull1, empty1, aempty1;
    logic [D:0]   count0, pkt0, count1, pkt1;

    aq_axis_pkt_fifo_if #(.FIFO_WIDTH(W)) s0 ();
    aq_axis_pkt_fifo_if #(.FIFO_WIDTH(W)) m0 ();
    aq_axis_pkt_fifo_if #(.FIFO_WIDTH(W)) s1 ();
    aq_axis_pkt_fifo_if #(.FIFO_WIDTH(W)) m1 ();

    assign s0.TVALID = svalid;
    assign s0.TDATA  = sdata;
    assign s0.TLAST  = slast;
    assign m0.TREADY = mready;
    assign s1.TVALID = svalid;
    assign s1.TDATA  = sdata;
    assign s1.TLAST  = slast;
    assign m1.TREADY = mready;

    aq_axis_pkt_fifo #(.FIFO_DEPTH(D), .FIFO_WIDTH(W), .PACKET_MODE(0)) u_dut_word (
        .ACLK(clk), .RST_N(rst_n), .FIFO_CLEAR(clr), .S_AXIS(s0), .M_AXIS(m0),
        .FIFO_WR_ALM_COUNT(almw), .FIFO_RD_ALM_COUNT(almr),
        .FIFO_WR_FULL(full0), .FIFO_WR_ALM_FULL(afull0), .FIFO_RD_EMPTY(empty0),
        .FIFO_RD_ALM_EMPTY(aempty0), .FIFO_COUNT(count0), .FIFO_PKT_COUNT(pkt0)
    );

    aq_axis_pkt_fifo #(.FIFO_DEPTH(D), .FIFO_WIDTH(W), .PACKET_MODE(1)) u_dut_pkt (
        .ACLK(clk), .RST_N(rst_n), .FIFO_CLEAR(clr), .S_AXIS(s1), .M_AXIS(m1),
        .FIFO_WR_ALM_COUNT(almw), .FIFO_RD_ALM_COUNT(almr),
        .FIFO_WR_FULL(full1), .FIFO_WR_ALM_FULL(afull1), .FIFO_RD_EMPTY(empty1),
        .FIFO_RD_ALM_EMPTY(aempty1), .FIFO_COUNT(count1), .FIFO_PKT_COUNT(pkt1)
    );

    always #5 clk = ~clk;

    // Reference model: contents as queues of {last, data}, plus packet tallies.
    logic [W:0] mq0[$];
    logic [W:0] mq1[$];
    int         pk0 = 0;
    int         pk1 = 0;
    bit         esc1 = 1'b0;
    bit         ren = 1'b0;
    bit         acc1 = 1'b0;
    bit         rd1 = 1'b0;

    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    endtask

    function automatic bit exp_valid(input bit pm, input int cnt, input int pk, input bit es);
        if (cnt == 0) return 1'b0;
        if (!pm) return 1'b1;
        return (pk != 0) || es;
    endfunction

    task automatic check_dut(input string p, input bit pm, input int cnt, input int pk,
                             input bit es, input logic [W:0] head,
                             input logic tr, input logic tv, input logic [W-1:0] td,
                             input logic tl, input logic fu, input logic af,
                             input logic em, input logic ae,
                             input logic [D:0] co, input logic [D:0] pc);
        bit ev;
        bit eaf;
        ev  = exp_valid(pm, cnt, pk, es);
        eaf = (int'(almw) > N) || (cnt >= N - int'(almw));
        check_eq({p, "_tready"}, 32'(tr), 32'(ren && (cnt != N)));
        check_eq({p, "_tvalid"}, 32'(tv), 32'(ev));
        if (ev) begin
            check_eq({p, "_tdata"}, 32'(td), 32'(head[W-1:0]));
            check_eq({p, "_tlast"}, 32'(tl), 32'(head[W]));
        end
        check_eq({p, "_full"},     32'(fu), 32'(cnt == N));
        check_eq({p, "_almfull"},  32'(af), 32'(eaf));
        check_eq({p, "_empty"},    32'(em), 32'(cnt == 0));
        check_eq({p, "_almempty"}, 32'(ae), 32'(cnt <= int'(almr)));
        check_eq({p, "_count"},    32'(co), 32'(cnt));
        check_eq({p, "_pktcount"}, 32'(pc), 32'(pk));
    endtask

    task automatic check_all();
        logic [W:0] h0;
        logic [W:0] h1;
        h0 = (mq0.size() > 0) ? mq0[0] : '0;
        h1 = (mq1.size() > 0) ? mq1[0] : '0;
        check_dut("word", 1'b0, mq0.size(), pk0, 1'b0, h0, s0.TREADY, m0.TVALID,
                  m0.TDATA, m0.TLAST, full0, afull0, empty0, aempty0, count0, pkt0);
        check_dut("pkt", 1'b1, mq1.size(), pk1, esc1, h1, s1.TREADY, m1.TVALID,
                  m1.TDATA, m1.TLAST, full1, afull1, empty1, aempty1, count1, pkt1);
    endtask

    task automatic model_flush();
        mq0.delete();
        mq1.delete();
        pk0  = 0;
        pk1  = 0;
        esc1 = 1'b0;
    endtask

    // Entered just after a rising edge with inputs applied; checks at the
    // falling edge, advances the model across the next rising edge.
    task automatic step();
        logic [W:0] e;
        int c0, c1;
        bit w0, w1, r0, r1;
        @(negedge clk);
        check_all();
        c0 = mq0.size();
        c1 = mq1.size();
        w0 = svalid && ren && (c0 != N);
        w1 = svalid && ren && (c1 != N);
        r0 = exp_valid(1'b0, c0, pk0, 1'b0) && mready;
        r1 = exp_valid(1'b1, c1, pk1, esc1) && mready;
        acc1 = 1'b0;
        rd1  = 1'b0;
        if (rst_n) begin
            if (clr) begin
                model_flush();
            end else begin
                acc1 = w1;
                rd1  = r1;
                if ((c1 == N) && (pk1 == 0)) esc1 = 1'b1;
                if (r0) begin e = mq0.pop_front(); if (e[W]) pk0--; end
                if (w0) begin mq0.push_back({slast, sdata}); if (slast) pk0++; end
                if (r1) begin
                    e = mq1.pop_front();
                    if (e[W]) begin pk1--; esc1 = 1'b0; end
                end
                if (w1) begin mq1.push_back({slast, sdata}); if (slast) pk1++; end
            end
            ren = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_flush();
        ren = 1'b0;
        #1 check_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, got, cyc;
        bit esc_seen;
        #1;
        // Reset and release
        repeat (3) step();
        check_eq("rst_tready", 32'(s0.TREADY), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("rel_tready", 32'(s0.TREADY), 32'd1);
        step();

        // Fill eight words then drain
        for (int i = 1; i <= 8; i++) begin
            svalid = 1'b1; sdata = W'(i); slast = (i == 8); mready = 1'b0;
            step();
        end
        svalid = 1'b0;
        step();
        check_eq("a_full", 32'(full0), 32'd1);
        check_eq("a_tready", 32'(s0.TREADY), 32'd0);
        check_eq("a_count", 32'(count0), 32'd8);
        mready = 1'b1;
        repeat (8) step();
        check_eq("a_empty", 32'(empty0), 32'd1);

        // One 4-beat packet with reads enabled
        for (int i = 1; i <= 4; i++) begin
            svalid = 1'b1; sdata = W'(16'hB0 + i); slast = (i == 4);
            step();
        end
        svalid = 1'b0;
        repeat (6) step();
        check_eq("b_pktcount", 32'(pkt1), 32'd0);

        // Oversize packet: 12 beats, TLAST only on the last
        clr = 1'b1; step(); clr = 1'b0;
        b = 1; got = 0; cyc = 0; esc_seen = 1'b0;
        while (got < 12 && cyc < 300) begin
            svalid = (b <= 12); sdata = W'(16'hC00 + b); slast = (b == 12);
            mready = (cyc >= 12);
            step();
            if (acc1) b++;
            if (rd1) got++;
            if (m1.TVALID && (pkt1 == '0)) esc_seen = 1'b1;
            cyc++;
        end
        check_eq("c_beats", 32'(got), 32'd12);
        check_eq("c_escape", 32'(esc_seen), 32'd1);
        svalid = 1'b0; mready = 1'b0;
        step();
        check_eq("c_tvalid_after", 32'(m1.TVALID), 32'd0);

        // Simultaneous read/write at count 5 and threshold flags
        clr = 1'b1; step(); clr = 1'b0;
        almw = 4'd2; almr = 4'd2;
        for (int i = 1; i <= 5; i++) begin
            svalid = 1'b1; sdata = W'(16'hD0 + i); slast = 1'b1;
            step();
        end
        sdata = 16'hD6; mready = 1'b1;
        step();
        svalid = 1'b0; mready = 1'b0;
        step();
        check_eq("d_count", 32'(count1), 32'd5);
        check_eq("d_pktcount", 32'(pkt1), 32'd5);
        check_eq("d_almfull5", 32'(afull0), 32'd0);
        svalid = 1'b1; sdata = 16'hD7;
        step();
        svalid = 1'b0;
        check_eq("d_almfull6", 32'(afull0), 32'd1);
        mready = 1'b1;
        repeat (3) step();
        check_eq("d_almempty3", 32'(aempty0), 32'd0);
        step();
        mready = 1'b0;
        check_eq("d_almempty2", 32'(aempty0), 32'd1);

        // Clear in the same cycle as a mid-packet write
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            svalid = 1'b1; sdata = W'(16'hE0 + i); slast = 1'b0;
            step();
        end
        clr = 1'b1; sdata = 16'hEE;
        step();
        clr = 1'b0; svalid = 1'b0;
        check_eq("e_count", 32'(count1), 32'd0);
        check_eq("e_pktcount", 32'(pkt1), 32'd0);
        svalid = 1'b1; sdata = 16'hEF; slast = 1'b1;
        step();
        svalid = 1'b0; mready = 1'b1;
        repeat (3) step();

        // Randomised traffic
        for (int i = 0; i < 700; i++) begin
            if (i % 50 == 0) begin
                almw = D'(0) + 4'($urandom_range(0, N + 3));
                almr = 4'($urandom_range(0, N + 1));
            end
            svalid = ($urandom_range(0, 3) != 0);
            sdata  = W'($urandom);
            slast  = (i < 350) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            mready = ($urandom_range(0, 2) != 0);
            clr    = ($urandom_range(0, 99) == 0);
            step();
        end
        clr = 1'b0;

        // Asynchronous reset mid-packet
        for (int i = 1; i <= 3; i++) begin
            svalid = 1'b1; sdata = W'(16'hF0 + i); slast = 1'b0; mready = 1'b0;
            step();
        end
        svalid = 1'b0;
        async_reset();
        step();
        rst_n = 1'b1;
        step();
        svalid = 1'b1; sdata = 16'hFA; slast = 1'b1; mready = 1'b1;
        step();
        svalid = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
